multicycle_control_unit: RTL and testbench

Multi-cycle successor to the single-cycle combinational Controlunit. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and emits the per-state datapath strobes. It adds load/store support and a memory-ready handshake with a timeout-to-halt. The block sits between the instruction register and the shared-memory datapath of the processor.

---
 rtl/multicycle_control_unit.sv | 243 ++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: steps each instruction through fetch, decode,
// execute, memory and writeback states and drives the datapath strobes.
// Memory states wait on mem_ready, and a wait that runs too long parks the
// unit in HALT until reset.
module multicycle_control_unit #(
  parameter int ALU_CTRL_W  = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            Opcode,
  input  logic [5:0]            Func,
  input  logic                  mem_ready,
  output logic                  ALUSrc,
  output logic                  RegDst,
  output logic                  RegWrite,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  MemToReg,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic                  instr_done,
  output logic                  illegal,
  output logic                  halted,
  output logic [3:0]            state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_R     = 4'd7,
    WB_I     = 4'd8,
    WB_MEM   = 4'd9,
    ILLEGAL  = 4'd10,
    HALT     = 4'd11
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // The counter never has to hold MEM_TIMEOUT itself: the wait cycle that
  // would bring it there goes straight to HALT instead.
  localparam int              CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       func_q, func_d;
  logic [3:0]       aluCode;
  logic             timeoutHit;
  logic [CNT_W-1:0] cntInc;

  function automatic logic rFuncLegal(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100,
      6'b100101, 6'b100110, 6'b101010: rFuncLegal = 1'b1;
      default:                         rFuncLegal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] rAluCode(input logic [5:0] f);
    case (f)
      6'b100010: rAluCode = ALU_SUB;
      6'b100100: rAluCode = ALU_AND;
      6'b100101: rAluCode = ALU_OR;
      6'b100110: rAluCode = ALU_XOR;
      6'b101010: rAluCode = ALU_SLT;
      default:   rAluCode = ALU_ADD;
    endcase
  endfunction

  function automatic logic [3:0] iAluCode(input logic [5:0] op);
    case (op)
      OP_ANDI: iAluCode = ALU_AND;
      OP_ORI:  iAluCode = ALU_OR;
      OP_XORI: iAluCode = ALU_XOR;
      default: iAluCode = ALU_ADD;
    endcase
  endfunction

  assign timeoutHit = (cnt_q == LIMIT_M1);
  assign cntInc     = cnt_q + CNT_W'(1);

  // State, wait counter and latched instruction fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      op_q    <= '0;
      func_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      func_q  <= func_d;
    end
  end

  // Next-state decode and per-state strobes; all outputs held low during reset.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    op_d       = op_q;
    func_d     = func_q;
    aluCode    = ALU_ADD;
    ALUSrc     = 1'b0;
    RegDst     = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemToReg   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    halted     = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = DECODE;
        end else if (timeoutHit) begin
          state_d = HALT;
        end else begin
          cnt_d = cntInc;
        end
      end
      DECODE: begin
        op_d   = Opcode;
        func_d = Func;
        case (Opcode)
          OP_RTYPE:                         state_d = rFuncLegal(Func) ? EXEC_R : ILLEGAL;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: state_d = EXEC_I;
          OP_LW, OP_SW:                     state_d = MEM_ADDR;
          default:                          state_d = ILLEGAL;
        endcase
      end
      EXEC_R: begin
        aluCode = rAluCode(func_q);
        state_d = WB_R;
      end
      WB_R: begin
        aluCode    = rAluCode(func_q);
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      EXEC_I: begin
        ALUSrc  = 1'b1;
        aluCode = iAluCode(op_q);
        state_d = WB_I;
      end
      WB_I: begin
        ALUSrc     = 1'b1;
        aluCode    = iAluCode(op_q);
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEM_ADDR: begin
        ALUSrc  = 1'b1;
        state_d = (op_q == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          state_d = WB_MEM;
        end else if (timeoutHit) begin
          state_d = HALT;
        end else begin
          cnt_d = cntInc;
        end
      end
      WB_MEM: begin
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEM_WR: begin
        MemWrite = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = FETCH;
        end else if (timeoutHit) begin
          state_d = HALT;
        end else begin
          cnt_d = cntInc;
        end
      end
      ILLEGAL: begin
        illegal = 1'b1;
        state_d = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
    ALUControl = ALU_CTRL_W'(aluCode);
    state      = state_q;
    if (rst) begin
      ALUSrc     = 1'b0;
      RegDst     = 1'b0;
      RegWrite   = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      MemToReg   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      halted     = 1'b0;
      ALUControl = '0;
      state      = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Testbench for multicycle_control_unit. Each instruction is expanded into a
// queue of expected cycles (inputs to drive plus outputs to expect) built from
// the instruction class and chosen wait lengths, then replayed against the DUT.
module tb_multicycle_control_unit;

  localparam int ALU_CTRL_W  = 4;
  localparam int MEM_TIMEOUT = 15;

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;
  localparam logic [3:0] AND = 4'b0000;
  localparam logic [3:0] OR  = 4'b0001;
  localparam logic [3:0] XOR = 4'b0011;
  localparam logic [3:0] SLT = 4'b0111;

  // Strobe vector order: ALUSrc RegDst RegWrite MemRead MemWrite MemToReg
  // IRWrite PCWrite instr_done illegal halted
  localparam logic [10:0] S_ALUSRC   = 11'b10000000000;
  localparam logic [10:0] S_REGDST   = 11'b01000000000;
  localparam logic [10:0] S_REGWRITE = 11'b00100000000;
  localparam logic [10:0] S_MEMREAD  = 11'b00010000000;
  localparam logic [10:0] S_MEMWRITE = 11'b00001000000;
  localparam logic [10:0] S_MEMTOREG = 11'b00000100000;
  localparam logic [10:0] S_IRWRITE  = 11'b00000010000;
  localparam logic [10:0] S_PCWRITE  = 11'b00000001000;
  localparam logic [10:0] S_DONE     = 11'b00000000100;
  localparam logic [10:0] S_ILLEGAL  = 11'b00000000010;
  localparam logic [10:0] S_HALTED   = 11'b00000000001;

  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BAD = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [5:0]            opcode, func;
  logic                  memReady;
  logic                  aluSrc, regDst, regWrite, memRead, memWrite, memToReg;
  logic                  irWrite, pcWrite, instrDone, illegalOut, haltedOut;
  logic [ALU_CTRL_W-1:0] aluControl;
  logic [3:0]            stateOut;

  int total = 0;
  int bad   = 0;
  int cycNo = 0;

  typedef struct {
    logic        mr;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [3:0]  st;
    logic [3:0]  alu;
    logic [10:0] strb;
  } cycle_t;

  cycle_t traceQ[$];

  multicycle_control_unit #(.ALU_CTRL_W(ALU_CTRL_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .Opcode(opcode), .Func(func), .mem_ready(memReady),
    .ALUSrc(aluSrc), .RegDst(regDst), .RegWrite(regWrite), .ALUControl(aluControl),
    .MemRead(memRead), .MemWrite(memWrite), .MemToReg(memToReg), .IRWrite(irWrite),
    .PCWrite(pcWrite), .instr_done(instrDone), .illegal(illegalOut), .halted(haltedOut),
    .state(stateOut)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycNo, observed, expected);
    end
  endtask

  function automatic logic [10:0] observedStrobes();
    return {aluSrc, regDst, regWrite, memRead, memWrite, memToReg,
            irWrite, pcWrite, instrDone, illegalOut, haltedOut};
  endfunction

  // Instruction classes and ALU operations straight from the ISA table.
  function automatic void classify(input logic [5:0] op, input logic [5:0] fn,
                                   output int cls, output logic [3:0] alu);
    cls = C_BAD;
    alu = ADD;
    if (op == 6'd0) begin
      case (fn)
        6'b100000: begin cls = C_R; alu = ADD; end
        6'b100010: begin cls = C_R; alu = SUB; end
        6'b100100: begin cls = C_R; alu = AND; end
        6'b100101: begin cls = C_R; alu = OR;  end
        6'b100110: begin cls = C_R; alu = XOR; end
        6'b101010: begin cls = C_R; alu = SLT; end
        default: ;
      endcase
    end else begin
      case (op)
        6'b001000: begin cls = C_I; alu = ADD; end
        6'b001100: begin cls = C_I; alu = AND; end
        6'b001101: begin cls = C_I; alu = OR;  end
        6'b001110: begin cls = C_I; alu = XOR; end
        6'b100011: cls = C_LW;
        6'b101011: cls = C_SW;
        default: ;
      endcase
    end
  endfunction

  // Appends one expected cycle; instruction fields are random outside decode.
  task automatic pushCycle(input logic mr, input logic isDecode, input logic [5:0] op,
                           input logic [5:0] fn, input int st, input logic [3:0] alu,
                           input logic [10:0] strb);
    cycle_t c;
    c.mr   = mr;
    c.op   = isDecode ? op : 6'($urandom_range(0, 63));
    c.fn   = isDecode ? fn : 6'($urandom_range(0, 63));
    c.st   = 4'(st);
    c.alu  = alu;
    c.strb = strb;
    traceQ.push_back(c);
  endtask

  // Memory wait phase: waits low cycles followed by one completing cycle.
  task automatic pushWait(input int waits, input int st, input logic [10:0] busy,
                          input logic [10:0] finish);
    for (int i = 0; i < waits; i++) pushCycle(1'b0, 1'b0, 6'd0, 6'd0, st, ADD, busy);
    pushCycle(1'b1, 1'b0, 6'd0, 6'd0, st, ADD, busy | finish);
  endtask

  // Expands one instruction into its full expected cycle sequence.
  task automatic addInstr(input logic [5:0] op, input logic [5:0] fn,
                          input int fetchWaits, input int memWaits);
    int         cls;
    logic [3:0] alu;
    classify(op, fn, cls, alu);
    pushWait(fetchWaits, 0, S_MEMREAD, S_IRWRITE | S_PCWRITE);
    pushCycle(1'($urandom_range(0, 1)), 1'b1, op, fn, 1, ADD, '0);
    case (cls)
      C_R: begin
        pushCycle(1'($urandom_range(0, 1)), 1'b0, 0, 0, 2, alu, '0);
        pushCycle(1'($urandom_range(0, 1)), 1'b0, 0, 0, 7, alu, S_REGWRITE | S_REGDST | S_DONE);
      end
      C_I: begin
        pushCycle(1'($urandom_range(0, 1)), 1'b0, 0, 0, 3, alu, S_ALUSRC);
        pushCycle(1'($urandom_range(0, 1)), 1'b0, 0, 0, 8, alu, S_ALUSRC | S_REGWRITE | S_DONE);
      end
      C_LW: begin
        pushCycle(1'($urandom_range(0, 1)), 1'b0, 0, 0, 4, ADD, S_ALUSRC);
        pushWait(memWaits, 5, S_MEMREAD, '0);
        pushCycle(1'($urandom_range(0, 1)), 1'b0, 0, 0, 9, ADD, S_REGWRITE | S_MEMTOREG | S_DONE);
      end
      C_SW: begin
        pushCycle(1'($urandom_range(0, 1)), 1'b0, 0, 0, 4, ADD, S_ALUSRC);
        pushWait(memWaits, 6, S_MEMWRITE, S_DONE);
      end
      default: pushCycle(1'($urandom_range(0, 1)), 1'b0, 0, 0, 10, ADD, S_ILLEGAL);
    endcase
  endtask

  // Replays up to limit queued cycles (all if negative) and drops the rest.
  // Entered and left just after a rising edge; outputs checked on the falling edge.
  task automatic applyStimulus(input int limit);
    cycle_t c;
    int     n = 0;
    while (traceQ.size() > 0) begin
      if (limit >= 0 && n == limit) begin
        traceQ.delete();
        break;
      end
      c = traceQ.pop_front();
      memReady = c.mr;
      opcode   = c.op;
      func     = c.fn;
      @(negedge clk);
      checkOutput("state", 32'(stateOut), 32'(c.st));
      checkOutput("alu", 32'(aluControl), 32'(c.alu));
      checkOutput("strobes", 32'(observedStrobes()), 32'(c.strb));
      @(posedge clk);
      #1;
      cycNo++;
      n++;
    end
  endtask

  // Asserts reset between edges, checks outputs are all low, then releases.
  task automatic doReset(input string tag);
    rst = 1'b1;
    #1;
    checkOutput({tag, "_state"}, 32'(stateOut), 32'd0);
    checkOutput({tag, "_alu"}, 32'(aluControl), 32'd0);
    checkOutput({tag, "_strobes"}, 32'(observedStrobes()), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_hold"}, 32'(observedStrobes()), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [5:0] randomOp();
    logic [5:0] pool [9] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B};
    if ($urandom_range(0, 9) == 0) return 6'($urandom_range(0, 63));
    return pool[$urandom_range(0, 8)];
  endfunction

  function automatic logic [5:0] randomFunc();
    logic [5:0] pool [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A};
    if ($urandom_range(0, 4) == 0) return 6'($urandom_range(0, 63));
    return pool[$urandom_range(0, 5)];
  endfunction

  function automatic int randomWaits();
    if ($urandom_range(0, 4) == 0) return $urandom_range(0, MEM_TIMEOUT - 1);
    return $urandom_range(0, 2);
  endfunction

  // Main sequence: directed instructions, random stream, timeout and reset cases.
  initial begin
    rst      = 1'b1;
    opcode   = '0;
    func     = '0;
    memReady = 1'b0;
    @(posedge clk);
    #1;
    doReset("reset");

    addInstr(6'b000000, 6'b100000, 0, 0);
    addInstr(6'b001100, 6'b000000, 0, 0);
    addInstr(6'b100011, 6'b000000, 0, 3);
    addInstr(6'b101011, 6'b000000, 0, 0);
    addInstr(6'b111111, 6'b000000, 0, 0);
    addInstr(6'b000000, 6'b000001, 0, 0);
    applyStimulus(-1);

    for (int i = 0; i < 60; i++) addInstr(randomOp(), randomFunc(), randomWaits(), randomWaits());
    applyStimulus(-1);

    for (int i = 0; i < MEM_TIMEOUT; i++) pushCycle(1'b0, 1'b0, 0, 0, 0, ADD, S_MEMREAD);
    for (int i = 0; i < 50; i++) pushCycle(1'($urandom_range(0, 1)), 1'b0, 0, 0, 11, ADD, S_HALTED);
    applyStimulus(-1);
    doReset("halt_reset");

    addInstr(6'b001101, 6'b000000, MEM_TIMEOUT - 1, 0);
    addInstr(6'b100011, 6'b000000, 0, MEM_TIMEOUT - 1);
    addInstr(6'b101011, 6'b000000, 0, MEM_TIMEOUT - 1);
    applyStimulus(-1);

    addInstr(6'b000000, 6'b100010, 0, 0);
    applyStimulus(3);
    doReset("mid_wbr");
    addInstr(6'b101011, 6'b000000, 0, 4);
    applyStimulus(5);
    doReset("mid_memwr");
    addInstr(6'b001000, 6'b000000, 0, 0);
    applyStimulus(-1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the bench always ends even if the queue replay stalls.
  initial begin
    #200000;
    $display("[TB] FAIL timeout cycle=%0d observed=running expected=finished", cycNo);
    $fatal(1, "[TB] time limit reached");
  end

endmodule
